ibex_wb_pipe_bridge: RTL and testbench



---
 rtl/ibex_wb_pkg.sv | 19 +
 rtl/ibex_wb_timeout.sv | 41 ++++
 rtl/ibex_wb_pipe_bridge.sv | 130 +++++++++++++
 tb/tb_ibex_wb_pipe_bridge.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_wb_pkg.sv
// Shared types for the Ibex-to-Wishbone pipelined bridge.
package ibex_wb_pkg;

    // Widest data bus the response register can carry; narrower buses zero-extend.
    localparam int unsigned RspDataMaxW = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ABORT  = 2'd2
    } bridge_state_e;

    typedef struct packed {
        logic                   valid;
        logic                   err;
        logic [RspDataMaxW-1:0] data;
    } wb_rsp_t;

endpackage

// File: rtl/ibex_wb_timeout.sv
// Idle-bus watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches TimeoutCycles (0 disables it).
module ibex_wb_timeout #(
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);

    if (TimeoutCycles == 0) begin : g_off
        logic unused_ctrl;
        assign unused_ctrl = clk_i ^ rst_i ^ en_i ^ clr_i;
        assign expired_o   = 1'b0;
    end else begin : g_on
        localparam int unsigned   TW    = $clog2(TimeoutCycles + 1);
        localparam logic [TW-1:0] Limit = TW'(TimeoutCycles);

        logic [TW-1:0] tmo_q, tmo_d;

        always_comb begin
            tmo_d = tmo_q;
            if (clr_i) begin
                tmo_d = '0;
            end else if (en_i && (tmo_q != Limit)) begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) tmo_q <= '0;
            else       tmo_q <= tmo_d;
        end

        // Fires on the cycle the count lands on the limit so the FSM can leave in step.
        assign expired_o = en_i && (tmo_d == Limit);
    end

endmodule

// File: rtl/ibex_wb_pipe_bridge.sv
// Ibex req/gnt/rvalid port to Wishbone B4 pipelined master, with a bounded
// number of in-flight transfers and a timeout abort that fails lost transfers.
module ibex_wb_pipe_bridge
    import ibex_wb_pkg::*;
#(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned TimeoutCycles  = 256
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            core_req_i,
    output logic            core_gnt_o,
    input  logic            core_we_i,
    input  logic [DW/8-1:0] core_be_i,
    input  logic [AW-1:0]   core_addr_i,
    input  logic [DW-1:0]   core_wdata_i,
    output logic            core_rvalid_o,
    output logic [DW-1:0]   core_rdata_o,
    output logic            core_err_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [DW-1:0]   wb_dat_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic            wb_stall_i,
    output logic            spurious_o,
    output logic            timeout_o
);

    localparam int unsigned   CW     = $clog2(MaxOutstanding + 1);
    localparam logic [CW-1:0] MaxCnt = CW'(MaxOutstanding);

    bridge_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    wb_rsp_t       rsp_q, rsp_d;
    logic          spurious_q, spurious_d;
    logic          timeout_q, timeout_d;
    logic          cnt_zero, bus_rsp, rsp_take, expired;
    logic          unused_rsp;

    assign cnt_zero = (cnt_q == '0);
    assign bus_rsp  = wb_ack_i | wb_err_i;
    // Bus responses only count against live transfers; ABORT owns the counter.
    assign rsp_take = bus_rsp && !cnt_zero && (state_q != ABORT);

    assign wb_stb_o   = core_req_i && (cnt_q != MaxCnt) && (state_q != ABORT);
    assign core_gnt_o = wb_stb_o && !wb_stall_i;
    assign wb_cyc_o   = (state_q != ABORT) && (wb_stb_o || !cnt_zero);
    assign wb_we_o    = core_we_i;
    assign wb_adr_o   = core_addr_i;
    assign wb_sel_o   = core_be_i;
    assign wb_dat_o   = core_wdata_i;

    ibex_wb_timeout #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (state_q == ACTIVE),
        .clr_i    (rsp_take || cnt_zero),
        .expired_o(expired)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rsp_d      = '0;
        spurious_d = spurious_q;
        timeout_d  = 1'b0;
        if (state_q == ABORT) begin
            // Drain: one error response per cycle for each lost transfer.
            if (!cnt_zero) begin
                cnt_d     = cnt_q - 1'b1;
                rsp_d.valid = 1'b1;
                rsp_d.err   = 1'b1;
            end
            if (cnt_d == '0) state_d = IDLE;
        end else begin
            if (bus_rsp && cnt_zero) spurious_d = 1'b1;
            if (rsp_take) begin
                rsp_d.valid = 1'b1;
                rsp_d.err   = wb_err_i;
                rsp_d.data  = wb_err_i ? '0 : RspDataMaxW'(wb_dat_i);
            end
            case ({core_gnt_o, rsp_take})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
            if (state_q == IDLE) begin
                if (core_gnt_o) state_d = ACTIVE;
            end else if (expired) begin
                state_d   = ABORT;
                timeout_d = 1'b1;
            end else if (cnt_d == '0) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rsp_q      <= '0;
            spurious_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rsp_q      <= rsp_d;
            spurious_q <= spurious_d;
            timeout_q  <= timeout_d;
        end
    end

    assign core_rvalid_o = rsp_q.valid;
    assign core_err_o    = rsp_q.err;
    assign core_rdata_o  = rsp_q.data[DW-1:0];
    assign spurious_o    = spurious_q;
    assign timeout_o     = timeout_q;
    assign unused_rsp    = ^rsp_q.data;

endmodule

// File: tb/tb_ibex_wb_pipe_bridge.sv
// Directed bench for ibex_wb_pipe_bridge with a transaction-level reference
// model compared every cycle, plus hand-computed literal expectations.
module tb_ibex_wb_pipe_bridge;

    localparam int MAXO = 2;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [3:0]  core_be = '0;
    logic [31:0] core_addr = '0, core_wdata = '0;
    logic        wb_ack = 1'b0, wb_err = 1'b0, wb_stall = 1'b0;
    logic [31:0] wb_dat = '0;

    logic        core_gnt_o, core_rvalid_o, core_err_o;
    logic [31:0] core_rdata_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        spurious_o, timeout_o;

    int checks = 0;
    int failures = 0;

    ibex_wb_pipe_bridge #(
        .AW(32), .DW(32), .MaxOutstanding(MAXO), .TimeoutCycles(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .core_req_i(core_req), .core_gnt_o(core_gnt_o), .core_we_i(core_we),
        .core_be_i(core_be), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat), .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_stall_i(wb_stall),
        .spurious_o(spurious_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        core_req = 0; core_we = 0; core_be = '0; core_addr = '0; core_wdata = '0;
        wb_ack = 0; wb_err = 0; wb_stall = 0; wb_dat = '0;
    endtask

    // Reference model: outstanding transfer count, abort mode, and the
    // response/flag values the core must see after each clock edge.
    int          m_out = 0, m_wait = 0;
    bit          m_abort = 0, m_tmo = 0, m_rv = 0, m_err = 0, m_spur = 0;
    logic [31:0] m_rdata = '0;

    always @(posedge clk or posedge rst) begin : model
        int          n_out, n_wait;
        bit          n_abort, n_tmo, n_rv, n_err, n_spur, hit, g, r;
        logic [31:0] n_rdata;
        if (rst) begin
            m_out <= 0; m_wait <= 0; m_abort <= 0; m_tmo <= 0;
            m_rv <= 0; m_err <= 0; m_rdata <= '0; m_spur <= 0;
        end else begin
            n_out = m_out; n_wait = m_wait; n_abort = m_abort; n_spur = m_spur;
            n_tmo = 0; n_rv = 0; n_err = 0; n_rdata = '0;
            hit = wb_ack || wb_err;
            if (m_abort) begin
                if (n_out > 0) begin n_rv = 1; n_err = 1; n_out--; end
                if (n_out == 0) n_abort = 0;
                n_wait = 0;
            end else begin
                g = core_req && (m_out < MAXO) && !wb_stall;
                r = hit && (m_out > 0);
                if (hit && m_out == 0) n_spur = 1;
                if (r) begin
                    n_rv = 1; n_err = wb_err; n_rdata = wb_err ? 32'h0 : wb_dat;
                end
                n_wait = (m_out > 0 && !r) ? m_wait + 1 : 0;
                n_out = m_out + int'(g) - int'(r);
                if (n_wait == TMO) begin n_abort = 1; n_tmo = 1; n_wait = 0; end
            end
            m_out <= n_out; m_wait <= n_wait; m_abort <= n_abort; m_tmo <= n_tmo;
            m_rv <= n_rv; m_err <= n_err; m_rdata <= n_rdata; m_spur <= n_spur;
        end
    end

    always @(negedge clk) begin
        chk("stb", wb_stb_o, core_req && (m_out < MAXO) && !m_abort);
        chk("gnt", core_gnt_o, core_req && (m_out < MAXO) && !m_abort && !wb_stall);
        chk("cyc", wb_cyc_o, !m_abort && ((core_req && m_out < MAXO) || m_out > 0));
        chk("adr", wb_adr_o, core_addr);
        chk("we", wb_we_o, core_we);
        chk("sel", wb_sel_o, core_be);
        chk("wdat", wb_dat_o, core_wdata);
        chk("rvalid", core_rvalid_o, m_rv);
        chk("err", core_err_o, m_err);
        chk("rdata", core_rdata_o, m_rdata);
        chk("spurious", spurious_o, m_spur);
        chk("timeout", timeout_o, m_tmo);
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin : stim
        int n;
        bit seen;
        idle_in();
        rst = 1;
        tick(); tick();
        @(negedge clk);
        chk("rst_rvalid", core_rvalid_o, 0);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_spur", spurious_o, 0);
        tick();
        rst = 0;
        tick();

        // Single read, ack two cycles after grant
        core_req = 1; core_addr = 32'h100; core_be = 4'hF;
        @(negedge clk); chk("t1_gnt", core_gnt_o, 1);
        tick(); core_req = 0; core_addr = 0; core_be = 0;
        @(negedge clk); chk("t1_cyc_wait", wb_cyc_o, 1);
        tick(); wb_ack = 1; wb_dat = 32'hDEADBEEF;
        @(negedge clk); chk("t1_rv_early", core_rvalid_o, 0);
        tick(); wb_ack = 0; wb_dat = 0;
        @(negedge clk);
        chk("t1_rvalid", core_rvalid_o, 1);
        chk("t1_rdata", core_rdata_o, 32'hDEADBEEF);
        chk("t1_err", core_err_o, 0);
        chk("t1_cyc_drop", wb_cyc_o, 0);
        tick();

        // Three back-to-back requests against a limit of two
        core_req = 1; core_addr = 32'h200; core_be = 4'hF;
        @(negedge clk); chk("t2_gnt0", core_gnt_o, 1);
        tick(); core_addr = 32'h204;
        @(negedge clk); chk("t2_gnt1", core_gnt_o, 1);
        tick(); core_addr = 32'h208; wb_ack = 1; wb_dat = 32'h11111111;
        @(negedge clk); chk("t2_full_stb", wb_stb_o, 0); chk("t2_full_gnt", core_gnt_o, 0);
        tick(); wb_ack = 0; wb_dat = 0;
        @(negedge clk); chk("t2_gnt2", core_gnt_o, 1); chk("t2_rd0", core_rdata_o, 32'h11111111);
        tick(); core_req = 0; core_addr = 0; core_be = 0; wb_ack = 1; wb_dat = 32'h22222222;
        @(negedge clk);
        tick(); wb_dat = 32'h33333333;
        @(negedge clk); chk("t2_rd1", core_rdata_o, 32'h22222222);
        tick(); wb_ack = 0; wb_dat = 0;
        @(negedge clk); chk("t2_rd2", core_rdata_o, 32'h33333333); chk("t2_rv2", core_rvalid_o, 1);
        tick();

        // Stall held for three cycles on a write
        core_req = 1; core_we = 1; core_addr = 32'h300; core_wdata = 32'hCAFEF00D;
        core_be = 4'h3; wb_stall = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_gnt", core_gnt_o, 0);
            chk("t3_stall_stb", wb_stb_o, 1);
            chk("t3_stall_adr", wb_adr_o, 32'h300);
            tick();
        end
        wb_stall = 0;
        @(negedge clk); chk("t3_gnt", core_gnt_o, 1);
        tick(); idle_in(); wb_ack = 1;
        @(negedge clk); chk("t3_no_regnt", core_gnt_o, 0);
        tick(); wb_ack = 0;
        @(negedge clk); chk("t3_rvalid", core_rvalid_o, 1); chk("t3_err", core_err_o, 0);
        tick();

        // Timeout: two transfers, slave never answers
        core_req = 1; core_addr = 32'h400; core_be = 4'hF;
        @(negedge clk); chk("t4_gnt0", core_gnt_o, 1);
        tick(); core_addr = 32'h404;
        @(negedge clk); chk("t4_gnt1", core_gnt_o, 1);
        tick(); idle_in();
        n = 0; seen = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (timeout_o) begin seen = 1; n = i; end
            else tick();
        end
        chk("t4_seen", seen, 1);
        chk("t4_delay", n, 8);
        chk("t4_cyc", wb_cyc_o, 0);
        tick();
        @(negedge clk); chk("t4_e0_rv", core_rvalid_o, 1); chk("t4_e0_err", core_err_o, 1);
        chk("t4_pulse_end", timeout_o, 0);
        tick();
        @(negedge clk); chk("t4_e1_rv", core_rvalid_o, 1); chk("t4_e1_err", core_err_o, 1);
        tick();
        core_req = 1; core_addr = 32'h408; core_be = 4'hF;
        @(negedge clk); chk("t4_rv_done", core_rvalid_o, 0); chk("t4_regnt", core_gnt_o, 1);
        tick(); idle_in(); wb_ack = 1; wb_dat = 32'h0BADF00D;
        @(negedge clk);
        tick(); wb_ack = 0; wb_dat = 0;
        @(negedge clk); chk("t4_post_rd", core_rdata_o, 32'h0BADF00D);
        tick();

        // Write answered with err, then ack+err together
        core_req = 1; core_we = 1; core_addr = 32'h500; core_wdata = 32'h12345678; core_be = 4'hC;
        @(negedge clk); chk("t5_gnt", core_gnt_o, 1);
        tick(); idle_in(); wb_err = 1;
        @(negedge clk);
        tick(); wb_err = 0;
        @(negedge clk); chk("t5_rv", core_rvalid_o, 1); chk("t5_err", core_err_o, 1);
        tick();
        core_req = 1; core_addr = 32'h504; core_be = 4'hF;
        @(negedge clk);
        tick(); idle_in(); wb_ack = 1; wb_err = 1; wb_dat = 32'hA5A5A5A5;
        @(negedge clk);
        tick(); idle_in();
        @(negedge clk); chk("t5_both_err", core_err_o, 1); chk("t5_both_rd", core_rdata_o, 0);
        tick();

        // Stray ack while idle
        wb_ack = 1; wb_dat = 32'h55;
        @(negedge clk);
        tick(); idle_in();
        @(negedge clk); chk("t6_spur", spurious_o, 1); chk("t6_no_rv", core_rvalid_o, 0);
        tick(); tick(); tick();
        @(negedge clk); chk("t6_spur_sticky", spurious_o, 1);
        tick();

        // Reset with two transfers in flight
        core_req = 1; core_addr = 32'h600; core_be = 4'hF;
        @(negedge clk);
        tick(); core_addr = 32'h604;
        @(negedge clk); chk("t7_gnt1", core_gnt_o, 1);
        tick(); rst = 1; idle_in();
        @(negedge clk);
        chk("t7_rst_cyc", wb_cyc_o, 0);
        chk("t7_rst_stb", wb_stb_o, 0);
        chk("t7_rst_rv", core_rvalid_o, 0);
        chk("t7_rst_spur", spurious_o, 0);
        chk("t7_rst_tmo", timeout_o, 0);
        tick(); rst = 0;
        tick(); wb_ack = 1; wb_dat = 32'h77;
        @(negedge clk);
        tick(); idle_in();
        @(negedge clk); chk("t7_no_rv", core_rvalid_o, 0); chk("t7_spur", spurious_o, 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
